multi_match_controller: RTL and testbench
=========================================

MULTI_MATCH_CONTROLLER -- requirements
Module: multi_match_controller

Interface
REQ-001 Parameter NUM_CH, 4, number of comparator channels (1..32).
REQ-002 Parameter ADDR_WIDTH, 8, width of the capture-memory write address.
REQ-003 Parameter MEM_WRAP, 1, 1 = address wraps at end of memory; 0 = stop and flag full.
REQ-004 Parameter TIMEOUT_CYCLES, 1024, compare-phase watchdog limit; used only when COMPARE_TIMEOUT_EN is defined.
REQ-005 Port clk  in  1  system clock; one clock, all logic on the rising edge.
REQ-006 Port n_rst  in  1  reset, synchronous and active-low.
REQ-007 Port update_done  in  1  comparator registers loaded.
REQ-008 Port ready  in  1  new frame available at input.
REQ-009 Port eop  in  1  end of packet.
REQ-010 Port error  in  1  receive error on the current packet.
REQ-011 Port rdempty  in  1  input FIFO empty.
REQ-012 Port match  in  NUM_CH  per-channel match flags, valid in COMPARE.
REQ-013 Port rdreq  out  1  input FIFO read request.
REQ-014 Port comp_load  out  1  comparator-register load select.
REQ-015 Port mem_wr  out  1  capture-memory write strobe.
REQ-016 Port mem_addr  out  ADDR_WIDTH  capture-memory write address.
REQ-017 Port match_id  out  $clog2(NUM_CH), minimum 1  index of the channel being written.
REQ-018 Port mem_full  out  1  sticky; memory exhausted (MEM_WRAP=0 only).
REQ-019 Port timeout  out  1  one-cycle pulse on compare watchdog expiry.

Function
REQ-020 States: RESET, LOAD_COMP, IDLE, LOAD_FIFO, COMPARE, RESOLVE, STORE, ERROR.
REQ-021 Transitions:
- RESET -> LOAD_COMP unconditionally.
- LOAD_COMP -> IDLE on update_done.
- IDLE -> LOAD_FIFO on ready.
- LOAD_FIFO -> ERROR on error; otherwise -> COMPARE on eop. error has priority when error and eop are asserted together.
- ERROR -> IDLE on eop.
- COMPARE -> RESOLVE on rdempty.
- RESOLVE -> STORE if any bit of match_vec is set, else -> IDLE.
- STORE -> IDLE in the cycle the last set bit is cleared.
REQ-022 comp_load is registered and equals 1 exactly while state is LOAD_COMP.
REQ-023 rdreq is combinational and equals (state==COMPARE && !rdempty), so the FIFO is never read when empty.
REQ-024 Internal match_vec: cleared on entry to COMPARE; ORed with match every COMPARE cycle; sticky until STORE.
REQ-025 STORE issues one mem_wr pulse per set bit of match_vec, lowest index first.
- match_id gives the index of the bit being written, and that bit is cleared in the same cycle.
- A vector with k set bits takes exactly k STORE cycles.
REQ-026 mem_wr, match_id and mem_addr are valid together in the same cycle; mem_addr increments by 1 in the cycle after each write.
REQ-027 With MEM_WRAP=1, mem_addr wraps from 2^ADDR_WIDTH-1 to 0, and mem_full stays 0.
REQ-028 With MEM_WRAP=0, the write to address 2^ADDR_WIDTH-1 sets mem_full.
- mem_addr holds at that address.
- Later STORE cycles still clear bits, but mem_wr stays 0.
- mem_full clears only on reset.
REQ-029 ready, eop and error are ignored in states where they are not listed as transition conditions.

Reset
REQ-030 When n_rst=0 at a clock edge, the next state is RESET and all outputs are 0.
- mem_addr=0, match_id=0, mem_full=0, match_vec=0, watchdog=0.
REQ-031 Reset mid-STORE aborts the store and emits no further mem_wr pulses.

Configuration
REQ-032 Macro COMPARE_TIMEOUT_EN defined: a watchdog counts consecutive COMPARE cycles.
- When the count reaches TIMEOUT_CYCLES with rdempty still 0, timeout pulses for one cycle.
- match_vec is discarded and state goes to IDLE.
- The counter clears on entry to COMPARE.
REQ-033 Macro COMPARE_TIMEOUT_EN undefined: no counter is synthesised, timeout is tied to 0, and COMPARE waits indefinitely.

Structure
REQ-034 Package sniffer_pkg holds the state enum typedef and the channel-index-width constant function.
REQ-035 Sub-module match_prio_enc is a parametrised lowest-index priority encoder with NUM_CH inputs, giving an index and a valid flag.

Verification (NUM_CH=4, ADDR_WIDTH=4, TIMEOUT_CYCLES=16)
REQ-036 Scenario: reset, then update_done after 3 cycles.
- comp_load is high for exactly those LOAD_COMP cycles.
- State reaches IDLE with all outputs 0.
REQ-037 Scenario: frame with match=4'b1010 pulsed once in COMPARE.
- Two mem_wr pulses: match_id 1 at addr 0, then match_id 3 at addr 1.
- Then IDLE.
REQ-038 Scenario: error and eop asserted together in LOAD_FIFO.
- State goes to ERROR, with no rdreq and no mem_wr.
- The next eop returns state to IDLE.
REQ-039 Scenario: MEM_WRAP=0, 17 single-match frames.
- Writes go to addresses 0..15 and mem_full sets on address 15.
- The 17th frame gives no mem_wr.
- With MEM_WRAP=1, the 17th frame writes address 0.
REQ-040 Scenario: COMPARE_TIMEOUT_EN defined, rdempty held at 0.
- timeout pulses after 16 COMPARE cycles and state goes to IDLE with no write.
- With the macro undefined, state stays in COMPARE.
REQ-041 Scenario: n_rst=0 during the second STORE cycle of match=4'b1111.
- Exactly one mem_wr is seen before reset.
- All outputs are 0 on the next cycle.

Source files
------------

// File: rtl/multi_match_controller_pkg.sv
// Shared types for the multi-match capture controller: the FSM state
// encoding and the helper that sizes the channel-index bus.
package sniffer_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_LOAD_COMP,
    ST_IDLE,
    ST_LOAD_FIFO,
    ST_COMPARE,
    ST_RESOLVE,
    ST_STORE,
    ST_ERROR
  } state_t;

  // Width of an index that can name any of num_ch channels; never below 1
  // so a single-channel build still has a usable match_id bus.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_match_controller_if.sv
// Handshake and capture-memory bus of the multi-match controller.
// master: the controller itself (issues rdreq and memory writes).
// slave:  the surrounding datapath (FIFO, comparators, capture memory).
interface multi_match_controller_if
  import sniffer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 8
) ();

  localparam int ID_W = ch_idx_w(NUM_CH);

  logic                  update_done;
  logic                  ready;
  logic                  eop;
  logic                  error;
  logic                  rdempty;
  logic [NUM_CH-1:0]     match;

  logic                  rdreq;
  logic                  comp_load;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ID_W-1:0]       match_id;
  logic                  mem_full;
  logic                  timeout;

  modport master (
    input  update_done, ready, eop, error, rdempty, match,
    output rdreq, comp_load, mem_wr, mem_addr, match_id, mem_full, timeout
  );

  modport slave (
    output update_done, ready, eop, error, rdempty, match,
    input  rdreq, comp_load, mem_wr, mem_addr, match_id, mem_full, timeout
  );

endinterface

// File: rtl/multi_match_controller_prio_enc.sv
// Lowest-index priority encoder: reports the position of the lowest set
// request bit and whether any bit is set at all.
module match_prio_enc
  import sniffer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_match_controller.sv
// Multi-match capture controller. Loads comparator registers, pulls one
// packet from the input FIFO per frame, accumulates per-channel match flags
// over the compare phase and writes one capture-memory entry per matching
// channel, lowest channel first.
// Optional feature: define COMPARE_TIMEOUT_EN to add a compare-phase
// watchdog that abandons a frame after TIMEOUT_CYCLES cycles in COMPARE.
module multi_match_controller
  import sniffer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_WRAP       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      n_rst,
  multi_match_controller_if.master bus
);

  localparam int                    ID_W      = ch_idx_w(NUM_CH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                state;
  state_t                state_next;
  logic [NUM_CH-1:0]     match_vec;
  logic [NUM_CH-1:0]     vec_rest;
  logic [ID_W-1:0]       enc_idx;
  logic                  enc_valid;
  logic                  comp_load_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_full_q;
  logic                  mem_wr_c;
  logic                  wd_expire;

  match_prio_enc #(
    .NUM_CH (NUM_CH),
    .IDX_W  (ID_W)
  ) u_prio_enc (
    .req   (match_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // match_vec with its lowest set bit removed; empty means the current
  // store beat is the last one of the frame.
  assign vec_rest = match_vec & (match_vec - NUM_CH'(1));

`ifdef COMPARE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Count consecutive COMPARE cycles; any other state holds it at zero so
  // every compare phase starts from a fresh count.
  always_ff @(posedge clk) begin
    if (!n_rst || state != ST_COMPARE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expire = (state == ST_COMPARE) && !bus.rdempty &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // Constant false: without the watchdog COMPARE waits for rdempty forever.
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode; inputs not named for a state are ignored there.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:     state_next = ST_LOAD_COMP;
      ST_LOAD_COMP: if (bus.update_done) state_next = ST_IDLE;
      ST_IDLE:      if (bus.ready) state_next = ST_LOAD_FIFO;
      ST_LOAD_FIFO: begin
        if (bus.error) begin
          state_next = ST_ERROR;
        end else if (bus.eop) begin
          state_next = ST_COMPARE;
        end
      end
      ST_ERROR:     if (bus.eop) state_next = ST_IDLE;
      ST_COMPARE: begin
        if (wd_expire) begin
          state_next = ST_IDLE;
        end else if (bus.rdempty) begin
          state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE:   state_next = (|match_vec) ? ST_STORE : ST_IDLE;
      ST_STORE:     if (vec_rest == '0) state_next = ST_IDLE;
      default:      state_next = ST_RESET;
    endcase
  end

  // State register; comp_load is registered off the next state so it is
  // high exactly for the cycles spent in LOAD_COMP.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= ST_RESET;
      comp_load_q <= 1'b0;
    end else begin
      state       <= state_next;
      comp_load_q <= (state_next == ST_LOAD_COMP);
    end
  end

  // Accumulate match flags across the compare phase, then retire one bit
  // per store beat.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      match_vec <= '0;
    end else begin
      case (state)
        ST_LOAD_FIFO: if (state_next == ST_COMPARE) match_vec <= '0;
        ST_COMPARE:   match_vec <= wd_expire ? '0 : (match_vec | bus.match);
        ST_STORE:     match_vec <= vec_rest;
        default:      match_vec <= match_vec;
      endcase
    end
  end

  // A strobe coinciding with a reset edge would be lost by the memory side
  // anyway, so it is suppressed to make a reset abort the store cleanly.
  assign mem_wr_c = (state == ST_STORE) && enc_valid && !mem_full_q && n_rst;

  // Write address advances after each write; without wrapping it parks on
  // the last entry and raises the sticky full flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_addr_q <= '0;
      mem_full_q <= 1'b0;
    end else if (mem_wr_c) begin
      if (MEM_WRAP == 0 && mem_addr_q == ADDR_LAST) begin
        mem_full_q <= 1'b1;
      end else begin
        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.rdreq     = (state == ST_COMPARE) && !bus.rdempty;
  assign bus.comp_load = comp_load_q;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.match_id  = (state == ST_STORE) ? enc_idx : '0;
  assign bus.mem_full  = mem_full_q;
  assign bus.timeout   = wd_expire;

endmodule

// File: tb/tb_multi_match_controller.sv
// Directed bench for multi_match_controller (NUM_CH=4, ADDR_WIDTH=4,
// TIMEOUT_CYCLES=16). Two instances share the same stimulus: one with
// address wrap-around, one that stops and flags full. Every vector is one
// clock cycle: inputs driven after the falling edge, outputs checked 1 ns
// later against hand-computed values for that same cycle.
module tb_multi_match_controller;

  typedef struct packed {
    logic       n_rst;
    logic       update_done;
    logic       ready;
    logic       eop;
    logic       error;
    logic       rdempty;
    logic [3:0] match;
  } stim_t;

  typedef struct packed {
    logic       rdreq;
    logic       comp_load;
    logic       mem_wr;
    logic [3:0] mem_addr;
    logic [1:0] match_id;
    logic       mem_full;
    logic       timeout;
  } resp_t;

  typedef struct {
    stim_t stim;
    resp_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       update_done;
  logic       ready;
  logic       eop;
  logic       error;
  logic       rdempty;
  logic [3:0] match;

  int n_vectors     = 0;
  int n_miscompares = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  multi_match_controller_if #(.NUM_CH(4), .ADDR_WIDTH(4)) bus_w ();
  multi_match_controller_if #(.NUM_CH(4), .ADDR_WIDTH(4)) bus_s ();

  assign bus_w.update_done = update_done;
  assign bus_w.ready       = ready;
  assign bus_w.eop         = eop;
  assign bus_w.error       = error;
  assign bus_w.rdempty     = rdempty;
  assign bus_w.match       = match;
  assign bus_s.update_done = update_done;
  assign bus_s.ready       = ready;
  assign bus_s.eop         = eop;
  assign bus_s.error       = error;
  assign bus_s.rdempty     = rdempty;
  assign bus_s.match       = match;

  multi_match_controller #(
    .NUM_CH(4), .ADDR_WIDTH(4), .MEM_WRAP(1), .TIMEOUT_CYCLES(16)
  ) dut_wrap (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_w.master)
  );

  multi_match_controller #(
    .NUM_CH(4), .ADDR_WIDTH(4), .MEM_WRAP(0), .TIMEOUT_CYCLES(16)
  ) dut_stop (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_s.master)
  );

  // ctl = {n_rst, update_done, ready, eop, error, rdempty}
  function automatic stim_t mkStim(input logic [5:0] ctl, input logic [3:0] m);
    return {ctl, m};
  endfunction

  // flags = {rdreq, comp_load, mem_wr}, ft = {mem_full, timeout}
  function automatic resp_t mkResp(input logic [2:0] flags, input logic [3:0] a,
                                   input logic [1:0] id, input logic [1:0] ft);
    return {flags, a, id, ft};
  endfunction

  function automatic resp_t quiet(input logic [3:0] a, input logic full);
    return mkResp(3'b000, a, 2'd0, {full, 1'b0});
  endfunction

  task automatic addRow(input stim_t s, input resp_t r);
    vec_t v;
    v.stim = s;
    v.exp  = r;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    n_rst       = s.n_rst;
    update_done = s.update_done;
    ready       = s.ready;
    eop         = s.eop;
    error       = s.error;
    rdempty     = s.rdempty;
    match       = s.match;
  endtask

  task automatic compareOne(input string tag, input string which,
                            input resp_t act, input resp_t exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s/%s: got rdreq=%b comp_load=%b mem_wr=%b addr=%0d id=%0d full=%b timeout=%b, expected rdreq=%b comp_load=%b mem_wr=%b addr=%0d id=%0d full=%b timeout=%b",
               tag, which, act.rdreq, act.comp_load, act.mem_wr, act.mem_addr,
               act.match_id, act.mem_full, act.timeout, exp.rdreq, exp.comp_load,
               exp.mem_wr, exp.mem_addr, exp.match_id, exp.mem_full, exp.timeout);
    end
  endtask

  task automatic checkOutput(input string tag, input resp_t exp_w, input resp_t exp_s);
    resp_t act_w;
    resp_t act_s;
    act_w = {bus_w.rdreq, bus_w.comp_load, bus_w.mem_wr, bus_w.mem_addr,
             bus_w.match_id, bus_w.mem_full, bus_w.timeout};
    act_s = {bus_s.rdreq, bus_s.comp_load, bus_s.mem_wr, bus_s.mem_addr,
             bus_s.match_id, bus_s.mem_full, bus_s.timeout};
    compareOne(tag, "wrap", act_w, exp_w);
    compareOne(tag, "stop", act_s, exp_s);
  endtask

  task automatic runCycle(input string tag, input stim_t s,
                          input resp_t exp_w, input resp_t exp_s);
    applyStimulus(s);
    #1;
    checkOutput(tag, exp_w, exp_s);
    @(negedge clk);
  endtask

  initial begin
    logic       rq;
    logic       to;

    // Bring-up, two frames (1010 match, error+eop) and an empty compare.
    addRow(mkStim(6'b000000, 4'b0000), quiet(4'd0, 1'b0));                 // RESET held
    addRow(mkStim(6'b100000, 4'b0000), quiet(4'd0, 1'b0));                 // RESET released
    addRow(mkStim(6'b100000, 4'b0000), mkResp(3'b010, 4'd0, 2'd0, 2'b00)); // LOAD_COMP 1
    addRow(mkStim(6'b101100, 4'b0000), mkResp(3'b010, 4'd0, 2'd0, 2'b00)); // LOAD_COMP 2
    addRow(mkStim(6'b110000, 4'b0000), mkResp(3'b010, 4'd0, 2'd0, 2'b00)); // LOAD_COMP 3
    addRow(mkStim(6'b100110, 4'b0000), quiet(4'd0, 1'b0));                 // IDLE, eop/error ignored
    addRow(mkStim(6'b101000, 4'b0000), quiet(4'd0, 1'b0));                 // IDLE ready
    addRow(mkStim(6'b100000, 4'b0100), quiet(4'd0, 1'b0));                 // LOAD_FIFO wait
    addRow(mkStim(6'b100100, 4'b0000), quiet(4'd0, 1'b0));                 // LOAD_FIFO eop
    addRow(mkStim(6'b100000, 4'b1010), mkResp(3'b100, 4'd0, 2'd0, 2'b00)); // COMPARE match
    addRow(mkStim(6'b101000, 4'b0000), mkResp(3'b100, 4'd0, 2'd0, 2'b00)); // COMPARE
    addRow(mkStim(6'b100001, 4'b0000), quiet(4'd0, 1'b0));                 // COMPARE empty
    addRow(mkStim(6'b100001, 4'b0000), quiet(4'd0, 1'b0));                 // RESOLVE
    addRow(mkStim(6'b100001, 4'b0000), mkResp(3'b001, 4'd0, 2'd1, 2'b00)); // STORE ch1
    addRow(mkStim(6'b101001, 4'b0000), mkResp(3'b001, 4'd1, 2'd3, 2'b00)); // STORE ch3
    addRow(mkStim(6'b101000, 4'b0000), quiet(4'd2, 1'b0));                 // IDLE ready
    addRow(mkStim(6'b100110, 4'b0000), quiet(4'd2, 1'b0));                 // LOAD_FIFO err+eop
    addRow(mkStim(6'b101000, 4'b0000), quiet(4'd2, 1'b0));                 // ERROR, no rdreq
    addRow(mkStim(6'b100100, 4'b0000), quiet(4'd2, 1'b0));                 // ERROR eop
    addRow(mkStim(6'b101000, 4'b0000), quiet(4'd2, 1'b0));                 // IDLE ready
    addRow(mkStim(6'b100100, 4'b0000), quiet(4'd2, 1'b0));                 // LOAD_FIFO eop
    addRow(mkStim(6'b100000, 4'b0000), mkResp(3'b100, 4'd2, 2'd0, 2'b00)); // COMPARE
    addRow(mkStim(6'b100001, 4'b0000), quiet(4'd2, 1'b0));                 // COMPARE empty
    addRow(mkStim(6'b100001, 4'b0000), quiet(4'd2, 1'b0));                 // RESOLVE, no match
    addRow(mkStim(6'b100000, 4'b0000), quiet(4'd2, 1'b0));                 // IDLE

    applyStimulus(mkStim(6'b000000, 4'b0000));
    repeat (3) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      runCycle($sformatf("table[%0d]", i), tbl[i].stim, tbl[i].exp, tbl[i].exp);
    end

    // Reset on the second store beat of a 1111 frame.
    runCycle("rst.idle",   mkStim(6'b101000, 4'b0000), quiet(4'd2, 1'b0), quiet(4'd2, 1'b0));
    runCycle("rst.lf",     mkStim(6'b100100, 4'b0000), quiet(4'd2, 1'b0), quiet(4'd2, 1'b0));
    runCycle("rst.cmp",    mkStim(6'b100001, 4'b1111), quiet(4'd2, 1'b0), quiet(4'd2, 1'b0));
    runCycle("rst.res",    mkStim(6'b100001, 4'b0000), quiet(4'd2, 1'b0), quiet(4'd2, 1'b0));
    runCycle("rst.store1", mkStim(6'b100001, 4'b0000),
             mkResp(3'b001, 4'd2, 2'd0, 2'b00), mkResp(3'b001, 4'd2, 2'd0, 2'b00));
    runCycle("rst.store2", mkStim(6'b000001, 4'b0000),
             mkResp(3'b000, 4'd3, 2'd1, 2'b00), mkResp(3'b000, 4'd3, 2'd1, 2'b00));
    runCycle("rst.held",   mkStim(6'b000000, 4'b0000), quiet(4'd0, 1'b0), quiet(4'd0, 1'b0));
    runCycle("rst.reset",  mkStim(6'b100000, 4'b0000), quiet(4'd0, 1'b0), quiet(4'd0, 1'b0));
    runCycle("rst.load",   mkStim(6'b110000, 4'b0000),
             mkResp(3'b010, 4'd0, 2'd0, 2'b00), mkResp(3'b010, 4'd0, 2'd0, 2'b00));
    runCycle("rst.idle2",  mkStim(6'b100000, 4'b0000), quiet(4'd0, 1'b0), quiet(4'd0, 1'b0));

    // 17 single-match frames: wrap instance rolls over, stop instance fills.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] addr_w;
      logic [3:0] addr_s;
      logic       full_s;
      logic [1:0] id;
      logic [3:0] m;
      addr_w = 4'(i % 16);
      addr_s = (i > 15) ? 4'd15 : 4'(i);
      full_s = (i > 15);
      id     = 2'(i % 4);
      m      = 4'b0001 << id;
      runCycle($sformatf("frame%0d.idle", i), mkStim(6'b101000, 4'b0000),
               quiet(addr_w, 1'b0), quiet(addr_s, full_s));
      runCycle($sformatf("frame%0d.lf", i), mkStim(6'b100100, 4'b0000),
               quiet(addr_w, 1'b0), quiet(addr_s, full_s));
      runCycle($sformatf("frame%0d.cmp", i), mkStim(6'b100001, m),
               quiet(addr_w, 1'b0), quiet(addr_s, full_s));
      runCycle($sformatf("frame%0d.res", i), mkStim(6'b100001, 4'b0000),
               quiet(addr_w, 1'b0), quiet(addr_s, full_s));
      runCycle($sformatf("frame%0d.store", i), mkStim(6'b100001, 4'b0000),
               mkResp(3'b001, addr_w, id, 2'b00),
               mkResp({2'b00, !full_s}, addr_s, id, {full_s, 1'b0}));
    end

    // Compare phase with the FIFO never draining.
    runCycle("wd.idle", mkStim(6'b101000, 4'b0000), quiet(4'd1, 1'b0), quiet(4'd15, 1'b1));
    runCycle("wd.lf",   mkStim(6'b100100, 4'b0000), quiet(4'd1, 1'b0), quiet(4'd15, 1'b1));
    for (int k = 1; k <= 20; k++) begin
`ifdef COMPARE_TIMEOUT_EN
      rq = (k <= 16);
      to = (k == 16);
`else
      rq = 1'b1;
      to = 1'b0;
`endif
      runCycle($sformatf("wd.cmp%0d", k), mkStim(6'b100000, 4'b0010),
               mkResp({rq, 2'b00}, 4'd1, 2'd0, {1'b0, to}),
               mkResp({rq, 2'b00}, 4'd15, 2'd0, {1'b1, to}));
    end
`ifdef COMPARE_TIMEOUT_EN
    runCycle("wd.after", mkStim(6'b100001, 4'b0000), quiet(4'd1, 1'b0), quiet(4'd15, 1'b1));
`else
    runCycle("wd.empty", mkStim(6'b100001, 4'b0000), quiet(4'd1, 1'b0), quiet(4'd15, 1'b1));
    runCycle("wd.res",   mkStim(6'b100001, 4'b0000), quiet(4'd1, 1'b0), quiet(4'd15, 1'b1));
    runCycle("wd.store", mkStim(6'b100001, 4'b0000),
             mkResp(3'b001, 4'd1, 2'd1, 2'b00), mkResp(3'b000, 4'd15, 2'd1, 2'b10));
    runCycle("wd.idle2", mkStim(6'b100000, 4'b0000), quiet(4'd2, 1'b0), quiet(4'd15, 1'b1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
